// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan timing generator for the color mapper.
//
// Walks a (DrawX, DrawY) counter pair across an H_TOTAL x V_TOTAL raster and
// decodes blank, hs and vs for the pixel currently on DrawX/DrawY. hs_d/vs_d
// are one-clock delayed copies for use alongside registered RGB. frame_start
// and vblank_start are single-cycle strobes; frame_count counts frame_start.
//
// Ports:
//   pixel_clk     in   clock
//   reset_n       in   asynchronous active-low reset
//   pixel_en      in   1 = advance one pixel this cycle
//   DrawX[9:0]    out  horizontal count, 0..H_TOTAL-1
//   DrawY[9:0]    out  vertical count, 0..V_TOTAL-1
//   blank         out  1 = visible pixel
//   hs, vs        out  syncs aligned with DrawX/DrawY (asserted = SYNC_ACTIVE)
//   hs_d, vs_d    out  hs/vs delayed one pixel_clk
//   frame_start   out  strobe on entering (0,0)
//   vblank_start  out  strobe on entering (0,V_VISIBLE)
//   frame_count   out  16-bit wrapping count of frame_start events
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        pixel_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..1024");
  end

  localparam logic [9:0]  H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits so an end bound of exactly 1024 does not wrap.
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_nq, vs_q, vs_nq;
  logic        hs_dly_q, vs_dly_q;
  logic        fs_q, fs_d, vbs_q, vbs_d;
  logic [15:0] fc_q;
  logic [10:0] xw, yw;

  // Next counter position plus a decode of that position, so the registered
  // decode describes the same pixel as the registered counters.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_MAX) begin
      x_d = '0;
      y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
    end
    xw      = {1'b0, x_d};
    yw      = {1'b0, y_d};
    blank_d = (xw < H_VIS) && (yw < V_VIS);
    hs_nq   = (xw >= HS_BEG && xw < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nq   = (yw >= VS_BEG && yw < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    fs_d    = (x_d == '0) && (y_d == '0);
    vbs_d   = (x_d == '0) && (yw == V_VIS);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= H_MAX;
      y_q      <= V_MAX;
      blank_q  <= 1'b0;
      hs_q     <= ~SYNC_ACTIVE;
      vs_q     <= ~SYNC_ACTIVE;
      hs_dly_q <= ~SYNC_ACTIVE;
      vs_dly_q <= ~SYNC_ACTIVE;
      fs_q     <= 1'b0;
      vbs_q    <= 1'b0;
      fc_q     <= '0;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
      // Strobes drop on every edge and are only re-armed by an enabled step.
      fs_q     <= 1'b0;
      vbs_q    <= 1'b0;
      if (pixel_en) begin
        x_q     <= x_d;
        y_q     <= y_d;
        blank_q <= blank_d;
        hs_q    <= hs_nq;
        vs_q    <= vs_nq;
        fs_q    <= fs_d;
        vbs_q   <= vbs_d;
        if (fs_d) begin
          fc_q <= fc_q + 16'd1;
        end
      end
    end
  end

  assign DrawX        = x_q;
  assign DrawY        = y_q;
  assign blank        = blank_q;
  assign hs           = hs_q;
  assign vs           = vs_q;
  assign hs_d         = hs_dly_q;
  assign vs_d         = vs_dly_q;
  assign frame_start  = fs_q;
  assign vblank_start = vbs_q;
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, pixel_en, en_s, en_w;

  logic [9:0]  DrawX, DrawY;
  logic        blank, hs, vs, hs_d, vs_d, frame_start, vblank_start;
  logic [15:0] frame_count;

  logic [9:0]  s_x, s_y;
  logic        s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_fs, s_vbs;
  logic [15:0] s_fc;

  logic [9:0]  w_x, w_y;
  logic        w_blank, w_hs, w_vs, w_hs_d, w_vs_d, w_fs, w_vbs;
  logic [15:0] w_fc;

  vga_timing_gen dut (
    .pixel_clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
    .hs_d(hs_d), .vs_d(vs_d), .frame_start(frame_start),
    .vblank_start(vblank_start), .frame_count(frame_count)
  );

  // Small raster: 16 x 12, hs low at X 10..12, vs low at Y 8..9.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_ACTIVE(1'b0)
  ) dut_s (
    .pixel_clk(clk), .reset_n(reset_n), .pixel_en(en_s),
    .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
    .hs_d(s_hs_d), .vs_d(s_vs_d), .frame_start(s_fs),
    .vblank_start(s_vbs), .frame_count(s_fc)
  );

  // 1 x 1 raster: every enabled edge is a new frame.
  vga_timing_gen #(
    .H_VISIBLE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_VISIBLE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_ACTIVE(1'b0)
  ) dut_w (
    .pixel_clk(clk), .reset_n(reset_n), .pixel_en(en_w),
    .DrawX(w_x), .DrawY(w_y), .blank(w_blank), .hs(w_hs), .vs(w_vs),
    .hs_d(w_hs_d), .vs_d(w_vs_d), .frame_start(w_fs),
    .vblank_start(w_vbs), .frame_count(w_fc)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank, hs, vs, hs_d, vs_d, fs, vbs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int   x;
    logic blank;
    logic hs;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t sb_q[$];

  // Reference model of the default 640x480 raster.
  int          mx, my;
  logic [15:0] mfc;
  logic        mfs, mvbs, mhsd, mvsd;

  function automatic logic m_hs(input int x);
    return !(x >= 656 && x < 752);
  endfunction

  function automatic logic m_vs(input int y);
    return !(y >= 490 && y < 492);
  endfunction

  function automatic obs_t m_out();
    obs_t o;
    o.x     = 10'(mx);
    o.y     = 10'(my);
    o.blank = (mx < 640) && (my < 480);
    o.hs    = m_hs(mx);
    o.vs    = m_vs(my);
    o.hs_d  = mhsd;
    o.vs_d  = mvsd;
    o.fs    = mfs;
    o.vbs   = mvbs;
    o.fc    = mfc;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, vblank_start, frame_count};
    return o;
  endfunction

  task automatic model_reset();
    mx = 799; my = 524; mfc = '0;
    mfs = 1'b0; mvbs = 1'b0; mhsd = 1'b1; mvsd = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_obs(input string name, input obs_t e);
    obs_t a;
    a = dut_obs();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d b=%b hs=%b vs=%b hsd=%b vsd=%b fs=%b vbs=%b fc=%0d expected x=%0d y=%0d b=%b hs=%b vs=%b hsd=%b vsd=%b fs=%b vbs=%b fc=%0d at %0t",
               name, a.x, a.y, a.blank, a.hs, a.vs, a.hs_d, a.vs_d, a.fs, a.vbs, a.fc,
               e.x, e.y, e.blank, e.hs, e.vs, e.hs_d, e.vs_d, e.fs, e.vbs, e.fc, $time);
    end
  endtask

  // Drive one cycle on the main DUT: expectation is queued with the stimulus
  // and checked once the edge has produced the output.
  task automatic step(input logic en);
    pixel_en = en;
    if (!reset_n) begin
      model_reset();
    end else begin
      mhsd = m_hs(mx);
      mvsd = m_vs(my);
      mfs  = 1'b0;
      mvbs = 1'b0;
      if (en) begin
        if (mx == 799) begin
          mx = 0;
          my = (my == 524) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
        mfs  = (mx == 0) && (my == 0);
        mvbs = (mx == 0) && (my == 480);
        if (mfs) mfc = mfc + 16'd1;
      end
    end
    sb_q.push_back(m_out());
    @(posedge clk);
    #1;
    cmp_obs("scoreboard", sb_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    int   blank_cnt, hs_cnt, hs_min, hs_max, x0, guard;
    logic prev_hs;
    int   last_fs, fs_cnt, vbs_cnt, vs_cnt, vs_bad, sblank_cnt;
    logic prev_fs, prev_shs, prev_svs;

    tbl[0] = '{0,   1'b1, 1'b1};
    tbl[1] = '{639, 1'b1, 1'b1};
    tbl[2] = '{640, 1'b0, 1'b1};
    tbl[3] = '{655, 1'b0, 1'b1};
    tbl[4] = '{656, 1'b0, 1'b0};
    tbl[5] = '{751, 1'b0, 1'b0};
    tbl[6] = '{752, 1'b0, 1'b1};
    tbl[7] = '{799, 1'b0, 1'b1};

    pixel_en = 1'b0; en_s = 1'b0; en_w = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    sb_q.push_back(m_out());
    cmp_obs("reset_state", sb_q.pop_front());
    step(1'b1);
    step(1'b1);
    reset_n = 1'b1;

    // First enabled edge after release.
    step(1'b1);
    chk("first_x", DrawX, 0);
    chk("first_y", DrawY, 0);
    chk("first_blank", blank, 1);
    chk("first_fs", frame_start, 1);
    chk("first_fc", frame_count, 1);

    // One full line with table-driven decode checks.
    blank_cnt = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1;
    for (int i = 0; i < 800; i++) begin
      if (i == 1) chk("fs_one_cycle", frame_start, 0);
      if (blank) blank_cnt++;
      if (hs == 1'b0) begin
        hs_cnt++;
        if (int'(DrawX) < hs_min) hs_min = int'(DrawX);
        if (int'(DrawX) > hs_max) hs_max = int'(DrawX);
      end
      for (int k = 0; k < 8; k++) begin
        if (int'(DrawX) == tbl[k].x) begin
          chk("tbl_blank", blank, tbl[k].blank);
          chk("tbl_hs", hs, tbl[k].hs);
        end
      end
      step(1'b1);
    end
    chk("line_wrap_x", DrawX, 0);
    chk("line_wrap_y", DrawY, 1);
    chk("blank_cycles", blank_cnt, 640);
    chk("hs_cycles", hs_cnt, 96);
    chk("hs_first_x", hs_min, 656);
    chk("hs_last_x", hs_max, 751);

    // pixel_en toggling: advance every other cycle, hs_d follows hs.
    x0 = int'(DrawX);
    for (int i = 0; i < 40; i++) begin
      prev_hs = hs;
      step((i % 2) == 0);
      chk("hs_d_prev", hs_d, prev_hs);
    end
    chk("toggle_adv", DrawX, x0 + 20);

    // Asynchronous reset mid-line.
    guard = 0;
    while (DrawX != 10'd300 && guard < 1000) begin
      step(1'b1);
      guard++;
    end
    chk("reach_300", DrawX, 300);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_x", DrawX, 799);
    chk("async_rst_y", DrawY, 524);
    chk("async_rst_blank", blank, 0);
    chk("async_rst_fc", frame_count, 0);
    chk("async_rst_sync", {hs, vs, frame_start}, 3'b110);
    model_reset();
    repeat (3) step(1'b1);
    reset_n = 1'b1;
    step(1'b1);
    chk("rerun_xy", {DrawX, DrawY}, 0);
    chk("rerun_fs", frame_start, 1);
    chk("rerun_fc", frame_count, 1);
    pixel_en = 1'b0;

    // Small raster: three full frames with pixel_en held high.
    en_s = 1'b1;
    last_fs = -1; fs_cnt = 0; vbs_cnt = 0; vs_cnt = 0; vs_bad = 0; sblank_cnt = 0;
    prev_fs = 1'b0; prev_shs = s_hs; prev_svs = s_vs;
    for (int i = 0; i < 3 * 192; i++) begin
      tick();
      if (prev_fs) chk("s_fs_drop", s_fs, 0);
      if (s_fs) begin
        fs_cnt++;
        if (last_fs >= 0) chk("s_fs_period", i - last_fs, 192);
        last_fs = i;
        chk("s_fs_pos", {s_x, s_y}, 0);
      end
      if (s_vbs) begin
        vbs_cnt++;
        chk("s_vbs_pos", {s_x, s_y}, {10'd0, 10'd6});
      end
      if (s_vs == 1'b0) begin
        vs_cnt++;
        if (s_y < 10'd8 || s_y > 10'd9) vs_bad++;
      end
      if (s_blank) sblank_cnt++;
      chk("s_hs_d", {s_hs_d, s_vs_d}, {prev_shs, prev_svs});
      prev_fs = s_fs; prev_shs = s_hs; prev_svs = s_vs;
    end
    chk("s_fs_count", fs_cnt, 3);
    chk("s_vbs_count", vbs_cnt, 3);
    chk("s_vs_cycles", vs_cnt, 96);
    chk("s_vs_lines", vs_bad, 0);
    chk("s_blank_cycles", sblank_cnt, 144);

    // Small raster with pixel_en toggling 1,0,1,0.
    fs_cnt = 0; prev_fs = 1'b0;
    for (int i = 0; i < 400; i++) begin
      en_s = ((i % 2) == 0);
      tick();
      if (prev_fs) chk("s_tog_fs_drop", s_fs, 0);
      if (s_fs) fs_cnt++;
      prev_fs = s_fs;
    end
    en_s = 1'b0;
    chk("s_tog_fs_count", fs_cnt, 2);
    chk("s_tog_pos", {s_x, s_y}, {10'd7, 10'd0});
    chk("s_tog_fc", s_fc, 5);

    // frame_count wrap on the 1x1 raster.
    en_w = 1'b1;
    repeat (65535) tick();
    chk("wrap_ffff", w_fc, 16'hFFFF);
    tick();
    chk("wrap_zero", w_fc, 16'h0000);
    chk("wrap_fs", w_fs, 1);
    chk("wrap_pos", {w_x, w_y}, 0);
    chk("wrap_misc", {w_blank, w_hs, w_vs, w_hs_d, w_vs_d, w_vbs}, 6'b111110);
    en_w = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster scan that the color mapper consumes: DrawX, DrawY, blank (display enable), hs and vs.
- Adds one-cycle-delayed copies of hs and vs (hs_d, vs_d). These line up with the color mapper's registered Red/Green/Blue, which lag DrawX/DrawY by one pixel_clk.
- Emits frame_start and vblank_start strobes and a frame counter, used by game logic to step object positions once per frame.
- Default mode is 640x480@60 from a 25 MHz pixel rate.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hs/vs

Ports:
- pixel_clk  in  1  single clock for the block
- reset_n  in  1  asynchronous, active-low reset
- pixel_en  in  1  advance enable; 1 = step one pixel this cycle
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (display on), 0 = blanking
- hs  out  1  horizontal sync, aligned with DrawX/DrawY
- vs  out  1  vertical sync, aligned with DrawX/DrawY
- hs_d  out  1  hs delayed one pixel_clk, for sync with registered RGB
- vs_d  out  1  vs delayed one pixel_clk
- frame_start  out  1  one-cycle strobe on entering (0,0)
- vblank_start  out  1  one-cycle strobe on entering (0,V_VISIBLE)
- frame_count  out  16  count of completed frame_start events

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be at most 1024; checked by an elaboration-time assertion.
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524)
  - hs=hs_d=vs=vs_d=~SYNC_ACTIVE; blank=0
  - frame_start=0, vblank_start=0, frame_count=0
- Release: first pixel_clk edge with pixel_en=1 moves the counters to (0,0).
- Counter step, on a pixel_clk edge with pixel_en=1:
  - If DrawX==H_TOTAL-1: DrawX<=0. DrawY<=0 if DrawY==V_TOTAL-1, else DrawY+1.
  - Otherwise DrawX<=DrawX+1.
- pixel_en=0: DrawX, DrawY, hs, vs, blank and frame_count hold.
- Decode: hs, vs and blank are registered, loaded from the next counter values so they describe the same pixel as DrawX/DrawY in the same cycle.
  - blank=1 iff X<H_VISIBLE and Y<V_VISIBLE.
  - hs=SYNC_ACTIVE iff H_VISIBLE+H_FP <= X < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vs=SYNC_ACTIVE iff V_VISIBLE+V_FP <= Y < V_VISIBLE+V_FP+V_SYNC (490..491), for every X on those lines.
- hs_d/vs_d: plain one-stage delay on every pixel_clk edge, independent of pixel_en.
- frame_start:
  - Asserted the cycle after an enabled edge that lands on (0,0).
  - Deasserted on the next pixel_clk edge regardless of pixel_en, so it is never high for 2 consecutive cycles.
- vblank_start: same rule, for landing on (0,V_VISIBLE).
- frame_count: increments on the same edge frame_start is set. 16-bit, wraps 0xFFFF->0x0000, no saturation.
- Reset mid-frame: all state returns to reset values at once. No partial line or frame completes. The next enabled edge starts a fresh frame at (0,0) with frame_start.
- No combinational path from any input to any output.

Test Plan:
- Reset, then pixel_en=1 constant -> first edge gives DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1. frame_start is 0 on the next cycle.
- Run one full line -> blank=1 for exactly 640 cycles. hs=0 for exactly 96 cycles, with DrawX 656..751. DrawY increments when DrawX goes 799->0.
- Run one full frame -> frame_start period is 420000 cycles. vblank_start fires once at (0,480). vs=0 for 1600 cycles, with DrawY 490..491.
- pixel_en toggling 1,0,1,0 -> counters advance every other cycle. frame_start stays high exactly 1 cycle. hs_d equals the previous cycle's hs on every cycle.
- Assert reset_n=0 at (300,200) for 3 cycles, with no clock edge needed -> outputs immediately read 799/524, blank=0, frame_count=0. After release, first enabled edge gives (0,0) and frame_start=1.
- Force 65536 frame_start events (shortened-parameter build, e.g. totals 4x3) -> frame_count wraps 0xFFFF->0x0000.
